serial_comparator_framed: RTL

Parametrised, multi-lane successor to the single-bit serial comparators. It accepts N_CH independent bit-serial operand pairs sharing one valid strobe and compares W-bit words, either MSB-first or LSB-first, unsigned or two's-complement signed. It produces one registered result per word with a result-valid pulse. It sits between serial links or deserialiser-free datapaths and control logic that needs per-word ordering decisions.

---
 rtl/serial_comparator_framed.sv | 99 +++++++++
 1 files changed

// File: rtl/serial_comparator_framed.sv
// rtl/serial_comparator_framed.sv - multi-lane framed bit-serial magnitude comparator
// Compares W-bit words per lane, MSB- or LSB-first, unsigned or two's-complement.
module serial_comparator_framed #(
  parameter int W    = 8,
  parameter int N_CH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [N_CH-1:0]       a,
  input  logic [N_CH-1:0]       b,
  input  logic                  msb_first,
  input  logic                  is_signed,
  input  logic                  clr,
  output logic [$clog2(W)-1:0]  bit_idx,
  output logic                  res_valid,
  output logic [N_CH-1:0]       a_less_b,
  output logic [N_CH-1:0]       a_eq_b,
  output logic [N_CH-1:0]       a_greater_b
);

  localparam int IW = $clog2(W);
  localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

  logic            mode_msb_r;
  logic            mode_sgn_r;
  logic [N_CH-1:0] eq_r;
  logic [N_CH-1:0] lt_r;

  logic            first_bit;
  logic            last_bit;
  logic            cur_msb;
  logic            cur_sgn;
  logic            sign_pos;
  logic [N_CH-1:0] eq_base;
  logic [N_CH-1:0] lt_base;
  logic [N_CH-1:0] diff;
  logic [N_CH-1:0] lt_bit;
  logic [N_CH-1:0] upd;
  logic [N_CH-1:0] eq_n;
  logic [N_CH-1:0] lt_n;

  // The first bit of a word uses the live mode inputs and a fresh eq=1/lt=0 base,
  // so consecutive words never leak state into each other.
  always_comb begin
    first_bit = (bit_idx == '0);
    last_bit  = (bit_idx == LAST_IDX);
    cur_msb   = first_bit ? msb_first : mode_msb_r;
    cur_sgn   = first_bit ? is_signed : mode_sgn_r;
    sign_pos  = cur_msb ? first_bit : last_bit;
    eq_base   = first_bit ? {N_CH{1'b1}} : eq_r;
    lt_base   = first_bit ? {N_CH{1'b0}} : lt_r;
    diff      = a ^ b;
    lt_bit    = (cur_sgn && sign_pos) ? (a & ~b) : (~a & b);
    // MSB-first locks on the first difference; LSB-first lets later bits override.
    upd       = diff & (cur_msb ? eq_base : {N_CH{1'b1}});
    eq_n      = eq_base & ~upd;
    lt_n      = (lt_base & ~upd) | (lt_bit & upd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx     <= '0;
      res_valid   <= 1'b0;
      mode_msb_r  <= 1'b1;
      mode_sgn_r  <= 1'b0;
      eq_r        <= {N_CH{1'b1}};
      lt_r        <= {N_CH{1'b0}};
      a_eq_b      <= {N_CH{1'b1}};
      a_less_b    <= {N_CH{1'b0}};
      a_greater_b <= {N_CH{1'b0}};
    end else if (clr) begin
      bit_idx   <= '0;
      res_valid <= 1'b0;
      eq_r      <= {N_CH{1'b1}};
      lt_r      <= {N_CH{1'b0}};
    end else begin
      res_valid <= 1'b0;
      if (in_valid) begin
        eq_r <= eq_n;
        lt_r <= lt_n;
        if (first_bit) begin
          mode_msb_r <= msb_first;
          mode_sgn_r <= is_signed;
        end
        if (last_bit) begin
          bit_idx     <= '0;
          res_valid   <= 1'b1;
          a_eq_b      <= eq_n;
          a_less_b    <= lt_n;
          a_greater_b <= ~eq_n & ~lt_n;
        end else begin
          bit_idx <= bit_idx + IW'(1);
        end
      end
    end
  end

endmodule
